// File: rtl/bits_to_bytes.sv
// bits_to_bytes: LSB-first bit-word to byte conversion, combinational and valid/ready serialized
module bits_to_bytes #(
   parameter int N_BYTES = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [N_BYTES*8-1:0]    bits_i,
   output logic [N_BYTES-1:0][7:0] bytes_o,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   output logic [7:0]              out_byte_o,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic                    out_last_o
);
   localparam int IW = N_BYTES > 1 ? $clog2(N_BYTES) : 1;
   localparam logic [IW-1:0] LAST = IW'(N_BYTES - 1);
   logic [N_BYTES*8-1:0] word;
   logic [IW-1:0]        idx;
   logic                 full;
   logic                 take;
   logic                 xfer;
   assign bytes_o     = bits_i;
   assign out_valid_o = full;
   assign out_byte_o  = word[8*idx +: 8];
   assign out_last_o  = full && (idx == LAST);
   assign xfer        = full && out_ready_i;
   assign in_ready_o  = !rst_i && (!full || (xfer && out_last_o));
   assign take        = in_valid_i && in_ready_o;
   // load a new word (possibly replacing a finishing one) or step through the current word
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         word <= '0;
         idx  <= '0;
         full <= 1'b0;
      end else if (take) begin
         word <= bits_i;
         idx  <= '0;
         full <= 1'b1;
      end else if (xfer) begin
         if (out_last_o) full <= 1'b0;
         else idx <= idx + IW'(1);
      end
   end
endmodule

// File: tb/tb_bits_to_bytes.sv
// tb_bits_to_bytes: directed and scoreboard checks of both conversion paths
module tb_bits_to_bytes;
   logic            clk_i = 1'b0;
   logic            rst_i;
   logic [31:0]     bits_i;
   logic [3:0][7:0] bytes_o;
   logic            in_valid_i;
   logic            in_ready_o;
   logic [7:0]      out_byte_o;
   logic            out_valid_o;
   logic            out_ready_i;
   logic            out_last_o;
   int              errors = 0;
   int              checks = 0;
   logic [8:0]      q[$];
   logic [31:0]     w;

   bits_to_bytes #(.N_BYTES(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .bits_i(bits_i), .bytes_o(bytes_o),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .out_byte_o(out_byte_o),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_last_o(out_last_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic par(input logic [31:0] v);
      bits_i = v;
      #1;
      for (int i = 0; i < 4; i++) chk($sformatf("par_byte%0d_%h", i, v), 32'(bytes_o[i]), 32'(v[8*i +: 8]));
   endtask

   // sample at the settled point before the edge: pop on transfer, push on accept, then advance one cycle
   task automatic tick();
      logic [8:0] e;
      #1;
      if (out_valid_o && out_ready_i) begin
         if (q.size() == 0) chk("unexpected_byte", 32'(out_byte_o), 32'hxx);
         else begin
            e = q.pop_front();
            chk("ser_byte", 32'(out_byte_o), 32'(e[7:0]));
            chk("ser_last", 32'(out_last_o), 32'(e[8]));
         end
      end
      if (in_valid_i && in_ready_o) begin
         w = bits_i;
         for (int i = 0; i < 4; i++) q.push_back({i == 3, w[8*i +: 8]});
      end
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   initial begin
      rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0; bits_i = '0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      #1;
      chk("rst_in_ready", 32'(in_ready_o), 0);
      chk("rst_out_valid", 32'(out_valid_o), 0);
      chk("rst_out_last", 32'(out_last_o), 0);
      chk("rst_out_byte", 32'(out_byte_o), 0);
      par(32'h89ABCDEF);
      par(32'h00000000);
      par(32'hFFFFFFFF);
      par(32'h03020100);
      for (int k = 0; k < 6; k++) par($urandom);
      // basic serialization
      rst_i = 1'b0; bits_i = 32'h89ABCDEF; in_valid_i = 1'b1; out_ready_i = 1'b1;
      tick();
      in_valid_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1 chk("basic_valid", 32'(out_valid_o), 1);
         tick();
      end
      #1 chk("basic_idle", 32'(out_valid_o), 0);
      chk("basic_drained", q.size(), 0);
      // back-to-back words with no bubble
      bits_i = 32'h03020100; in_valid_i = 1'b1;
      tick();
      bits_i = 32'hFFFFFFFF;
      for (int k = 0; k < 3; k++) begin
         #1 chk("b2b_ready_low", 32'(in_ready_o), 0);
         tick();
      end
      #1 chk("b2b_ready_on_last", 32'(in_ready_o), 1);
      chk("b2b_last_byte", 32'(out_byte_o), 32'h03);
      tick();
      in_valid_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1 chk("b2b_valid", 32'(out_valid_o), 1);
         tick();
      end
      #1 chk("b2b_idle", 32'(out_valid_o), 0);
      chk("b2b_drained", q.size(), 0);
      // backpressure while AB is presented
      bits_i = 32'h89ABCDEF; in_valid_i = 1'b1;
      tick();
      in_valid_i = 1'b0;
      tick();
      tick();
      out_ready_i = 1'b0; bits_i = 32'h11111111; in_valid_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_byte", 32'(out_byte_o), 32'hAB);
         chk("bp_last", 32'(out_last_o), 0);
         chk("bp_valid", 32'(out_valid_o), 1);
         chk("bp_ready", 32'(in_ready_o), 0);
         tick();
      end
      in_valid_i = 1'b0; out_ready_i = 1'b1;
      tick();
      tick();
      #1 chk("bp_idle", 32'(out_valid_o), 0);
      chk("bp_drained", q.size(), 0);
      // reset mid-word after CD has transferred
      bits_i = 32'h89ABCDEF; in_valid_i = 1'b1;
      tick();
      in_valid_i = 1'b0;
      tick();
      tick();
      rst_i = 1'b1; out_ready_i = 1'b0;
      tick();
      q.delete();
      #1;
      chk("midrst_valid", 32'(out_valid_o), 0);
      chk("midrst_byte", 32'(out_byte_o), 0);
      chk("midrst_ready", 32'(in_ready_o), 0);
      rst_i = 1'b0; out_ready_i = 1'b1;
      tick();
      #1 chk("postrst_valid", 32'(out_valid_o), 0);
      bits_i = 32'h11223344; in_valid_i = 1'b1;
      tick();
      in_valid_i = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      #1 chk("postrst_idle", 32'(out_valid_o), 0);
      chk("final_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
